// File: rtl/fetch_stage.sv
// IF-stage front end: owns the PC and the instruction-memory request/response handshake,
// presenting one instruction per cycle to IF/ID or a NOP bubble when nothing is ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallF,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pcF,
  output logic [31:0] o_pc_nxtF,
  output logic        o_validF
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StKill
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  assign pc_inc              = pc_q + 32'd4;
  assign redirect_tgt        = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  assign o_pcF     = pc_q;
  assign o_pc_nxtF = pc_inc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ibuf_d      = ibuf_q;
    o_imem_req  = 1'b0;
    o_imem_addr = pc_q;
    o_validF    = 1'b0;
    o_instr     = NOP_INSTR;

    unique case (state_q)
      StReq: begin
        o_imem_req = 1'b1;
        if (i_redirect) begin
          // The request issued this cycle is now stale; its response must be discarded.
          pc_d    = redirect_tgt;
          state_d = StKill;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (i_imem_rvalid) begin
          if (i_redirect) begin
            pc_d    = redirect_tgt;
            state_d = StReq;
          end else begin
            o_validF = 1'b1;
            o_instr  = i_imem_rdata;
            if (i_stallF) begin
              ibuf_d  = i_imem_rdata;
              state_d = StHold;
            end else begin
              // Overlap the next request with this response to sustain 1 IPC.
              o_imem_req  = 1'b1;
              o_imem_addr = pc_inc;
              pc_d        = pc_inc;
            end
          end
        end else if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = StKill;
        end
      end

      StHold: begin
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = StReq;
        end else begin
          o_validF = 1'b1;
          o_instr  = ibuf_q;
          if (!i_stallF) begin
            o_imem_req  = 1'b1;
            o_imem_addr = pc_inc;
            pc_d        = pc_inc;
            state_d     = StWait;
          end
        end
      end

      StKill: begin
        if (i_redirect) begin
          pc_d = redirect_tgt;
        end
        if (i_imem_rvalid) begin
          state_d = StReq;
        end
      end

      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      ibuf_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a latency-programmable imem responder plus a
// scoreboard of expected fetch PCs, with directed checks around stall, redirect and reset.
module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stallF;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pcF;
  logic [31:0] o_pc_nxtF;
  logic        o_validF;

  fetch_stage #(
    .RESET_PC (ResetPc),
    .NOP_INSTR(Nop)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stallF     (i_stallF),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_instr      (o_instr),
    .o_pcF        (o_pcF),
    .o_pc_nxtF    (o_pc_nxtF),
    .o_validF     (o_validF)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  // imem responder state
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  // Scoreboard: a valid output must match the queue head; it is consumed when not stalled.
  task automatic observe();
    logic [31:0] e;
    if (o_validF) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_valid", b2w(o_validF), 32'd0);
      end else begin
        e = exp_q[0];
        check_eq("sb_pcF", o_pcF, e);
        check_eq("sb_pc_nxtF", o_pc_nxtF, e + 32'd4);
        check_eq("sb_instr", o_instr, mem_word(e));
        if (!i_stallF) exp_q.delete(0);
      end
    end else begin
      check_eq("bubble_instr", o_instr, Nop);
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    observe();
  endtask

  task automatic advance();
    logic        req_s;
    logic [31:0] addr_s;
    req_s  = o_imem_req;
    addr_s = o_imem_addr;
    if (req_s) check_eq("one_outstanding", b2w(pend), 32'd0);
    @(posedge i_clk);
    #1;
    i_imem_rvalid = 1'b0;
    if (pend) cnt--;
    if (req_s) begin
      pend  = 1'b1;
      cnt   = lat - 1;
      paddr = addr_s;
    end
    if (pend && cnt == 0) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(paddr);
      pend          = 1'b0;
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int l);
    i_rst_n       = 1'b0;
    i_stallF      = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    pend          = 1'b0;
    cnt           = 0;
    lat           = l;
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, b2w(o_imem_req), 32'd1);
    check_eq({tag, "_addr"}, o_imem_addr, ResetPc);
    check_eq({tag, "_valid"}, b2w(o_validF), 32'd0);
    check_eq({tag, "_instr"}, o_instr, Nop);
    check_eq({tag, "_pcF"}, o_pcF, ResetPc);
    check_eq({tag, "_pc_nxtF"}, o_pc_nxtF, ResetPc + 32'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n       = 1'b0;
    i_stallF      = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    pend          = 1'b0;
    lat           = 1;
    #2;
    check_reset_outputs("por");

    // Latency 1, no stall: back-to-back fetch
    do_reset(1);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 6; c++) begin
      sample();
      check_eq("seq_req", b2w(o_imem_req), 32'd1);
      check_eq("seq_addr", o_imem_addr, 32'(4 * c));
      check_eq("seq_valid", b2w(o_validF), (c == 0) ? 32'd0 : 32'd1);
      advance();
    end
    drain(10);

    // Latency 3: valid pulses separated by bubbles
    do_reset(3);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 10; c++) begin
      sample();
      check_eq("lat3_valid", b2w(o_validF), (c > 0 && c % 3 == 0) ? 32'd1 : 32'd0);
      check_eq("lat3_req", b2w(o_imem_req), (c % 3 == 0) ? 32'd1 : 32'd0);
      advance();
    end
    drain(10);

    // Stall for 3 cycles as the word at pc=8 returns
    do_reset(1);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 8; c++) begin
      i_stallF = (c >= 3 && c <= 5);
      sample();
      if (c >= 3 && c <= 6) begin
        check_eq("stall_pcF", o_pcF, 32'h8);
        check_eq("stall_valid", b2w(o_validF), 32'd1);
        check_eq("stall_instr", o_instr, mem_word(32'h8));
      end
      if (c >= 3 && c <= 5) check_eq("stall_no_req", b2w(o_imem_req), 32'd0);
      if (c == 6) begin
        check_eq("release_req", b2w(o_imem_req), 32'd1);
        check_eq("release_addr", o_imem_addr, 32'hC);
      end
      advance();
    end
    i_stallF = 1'b0;
    drain(10);

    // Redirect while the request to 0x10 is outstanding (latency 2)
    do_reset(2);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
    for (int c = 0; c < 16; c++) begin
      i_redirect    = (c == 9);
      i_redirect_pc = 32'h100;
      sample();
      if (c == 10) begin
        check_eq("kill_valid", b2w(o_validF), 32'd0);
        check_eq("kill_no_req", b2w(o_imem_req), 32'd0);
      end
      if (c == 11) begin
        check_eq("redir_req", b2w(o_imem_req), 32'd1);
        check_eq("redir_addr", o_imem_addr, 32'h100);
      end
      advance();
    end
    i_redirect = 1'b0;
    drain(10);

    // Redirect with rvalid, then redirect during a stalled hold
    do_reset(1);
    exp_q = '{32'h0, 32'h100, 32'h104};
    for (int c = 0; c < 10; c++) begin
      i_redirect    = (c == 2 || c == 6);
      i_redirect_pc = (c == 2) ? 32'h103 : 32'h200;
      i_stallF      = (c == 5 || c == 6);
      sample();
      if (c == 2 || c == 6) begin
        check_eq("redir_drop_valid", b2w(o_validF), 32'd0);
        check_eq("redir_drop_instr", o_instr, Nop);
      end
      if (c == 3) check_eq("align_addr", o_imem_addr, 32'h100);
      if (c == 6) begin
        exp_q.delete(0);  // held 0x104 is squashed by the redirect
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
      end
      if (c == 7) begin
        check_eq("hold_redir_req", b2w(o_imem_req), 32'd1);
        check_eq("hold_redir_addr", o_imem_addr, 32'h200);
      end
      advance();
    end
    i_redirect = 1'b0;
    i_stallF   = 1'b0;
    drain(10);

    // Async reset in WAIT
    do_reset(2);
    exp_q.push_back(32'h0);
    step();
    sample();
    check_eq("wait_no_req", b2w(o_imem_req), 32'd0);
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("arst_wait");

    // Async reset in HOLD with pc=4
    do_reset(1);
    exp_q = '{32'h0, 32'h4};
    step();
    step();
    i_stallF = 1'b1;
    step();
    sample();
    check_eq("hold_pcF", o_pcF, 32'h4);
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("arst_hold");

    // Restart from RESET_PC, then PC wrap
    do_reset(1);
    sample();
    check_eq("restart_req", b2w(o_imem_req), 32'd1);
    check_eq("restart_addr", o_imem_addr, ResetPc);
    advance();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    sample();
    check_eq("wrap_drop_valid", b2w(o_validF), 32'd0);
    advance();
    i_redirect = 1'b0;
    sample();
    check_eq("wrap_req_addr", o_imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_pc_nxtF", o_pc_nxtF, 32'h0);
    advance();
    sample();
    check_eq("wrap_next_req", b2w(o_imem_req), 32'd1);
    check_eq("wrap_next_addr", o_imem_addr, 32'h0);
    advance();
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
